// File: rtl/updown_cnt_ctrl.sv
// -----------------------------------------------------------------------------
// updown_cnt_ctrl
//
// Run/stop/clear controller for a decimal up/down event counter. A three-state
// FSM (STOP, RUN, CLEAR) decides when the count may advance. The count steps
// once per i_tick while running, wraps at 0 and MAX_CNT, and follows the
// direction held in o_mode. The mode button toggles the direction in any
// state. Every button input is taken as a one-cycle press: a level held for N
// cycles counts as N presses.
//
// Parameters
//   MAX_CNT     terminal count; the count range is 0..MAX_CNT inclusive
//   CNT_W       count width, $clog2(MAX_CNT+1)
//
// Ports
//   clk         system clock, rising edge
//   rstn        asynchronous active-low reset
//   i_tick      count-enable pulse from the tick generator
//   i_run_btn   run/stop toggle pulse
//   i_clear_btn clear request pulse
//   i_mode_btn  direction toggle pulse
//   o_cnt       current count, registered
//   o_running   high while the FSM is in RUN, registered
//   o_mode      count direction, registered (0 = up, 1 = down)
//   o_state     FSM state: STOP=00, RUN=01, CLEAR=10
// -----------------------------------------------------------------------------
module updown_cnt_ctrl #(
  parameter int MAX_CNT = 9999,
  parameter int CNT_W   = $clog2(MAX_CNT + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_tick,
  input  logic             i_run_btn,
  input  logic             i_clear_btn,
  input  logic             i_mode_btn,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_running,
  output logic             o_mode,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CNT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_mode;
  logic             w_mode_nxt;
  logic             r_running;
  logic             w_step;

  // Up step with wrap. Any value above MAX_V (unreachable in normal operation)
  // also returns to zero so the count can never stay out of range.
  function automatic logic [CNT_W-1:0] f_step_up(input logic [CNT_W-1:0] v);
    if (v >= MAX_V) begin
      return '0;
    end
    return v + CNT_W'(1);
  endfunction

  // Down step with wrap to MAX_V; an out-of-range value is pulled back to
  // MAX_V as well.
  function automatic logic [CNT_W-1:0] f_step_down(input logic [CNT_W-1:0] v);
    if ((v == '0) || (v > MAX_V)) begin
      return MAX_V;
    end
    return v - CNT_W'(1);
  endfunction

  // Next-state logic. Clear outranks run in both STOP and RUN; CLEAR is a
  // single-cycle state that ignores the run and clear buttons.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_STOP: begin
        if (i_clear_btn) begin
          w_state_nxt = ST_CLEAR;
        end else if (i_run_btn) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_clear_btn) begin
          w_state_nxt = ST_CLEAR;
        end else if (i_run_btn) begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_CLEAR: begin
        w_state_nxt = ST_STOP;
      end
      default: begin
        w_state_nxt = ST_STOP;
      end
    endcase
  end

  // A tick is counted only from RUN and only when no clear is requested. A run
  // press in the same cycle still lets the tick through (the FSM leaves RUN on
  // this edge, after the step). In STOP the tick is never counted.
  assign w_step = (r_state == ST_RUN) && i_tick && !i_clear_btn;

  // Count datapath. The count is zeroed on the edge that enters CLEAR so the
  // zero is visible together with o_state == CLEAR. The step direction is the
  // current r_mode, so a mode press in the same cycle affects the next tick.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_state_nxt == ST_CLEAR || r_state == ST_CLEAR) begin
      w_cnt_nxt = '0;
    end else if (w_step) begin
      if (r_mode) begin
        w_cnt_nxt = f_step_down(r_cnt);
      end else begin
        w_cnt_nxt = f_step_up(r_cnt);
      end
    end
  end

  // The direction toggles in every state, including CLEAR.
  assign w_mode_nxt = r_mode ^ i_mode_btn;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_STOP;
      r_cnt     <= '0;
      r_mode    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mode    <= w_mode_nxt;
      // Registered from the next state so it lines up with o_state.
      r_running <= (w_state_nxt == ST_RUN);
    end
  end

  assign o_cnt     = r_cnt;
  assign o_running = r_running;
  assign o_mode    = r_mode;
  assign o_state   = r_state;

endmodule

// File: tb/tb_updown_cnt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_updown_cnt_ctrl
//
// Self-checking bench for updown_cnt_ctrl. Each driven cycle advances a
// behavioural model; the predicted outputs are queued and compared with the
// DUT one edge later. Directed sequences cover reset, counting, wrap,
// clear priority, run/tick and mode/tick collisions and mid-run reset, then a
// random phase exercises arbitrary button and tick combinations.
// -----------------------------------------------------------------------------
module tb_updown_cnt_ctrl;

  localparam int MAX_CNT = 9999;
  localparam int CNT_W   = 14;

  logic             clk;
  logic             rstn;
  logic             i_tick;
  logic             i_run_btn;
  logic             i_clear_btn;
  logic             i_mode_btn;
  logic [CNT_W-1:0] o_cnt;
  logic             o_running;
  logic             o_mode;
  logic [1:0]       o_state;

  int n_checks;
  int n_errors;

  typedef struct {
    int cnt;
    int running;
    int mode;
    int st;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state: 0 = STOP, 1 = RUN, 2 = CLEAR
  int m_cnt;
  int m_mode;
  int m_state;

  updown_cnt_ctrl #(
    .MAX_CNT (MAX_CNT),
    .CNT_W   (CNT_W)
  ) u_dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_tick      (i_tick),
    .i_run_btn   (i_run_btn),
    .i_clear_btn (i_clear_btn),
    .i_mode_btn  (i_mode_btn),
    .o_cnt       (o_cnt),
    .o_running   (o_running),
    .o_mode      (o_mode),
    .o_state     (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_mode  = 0;
    m_state = 0;
  endtask

  // Advance the model by one edge with the given inputs and queue the result.
  task automatic model_step(input bit run, input bit clr, input bit md, input bit tk);
    int   nxt;
    exp_t e;
    case (m_state)
      0:       nxt = clr ? 2 : (run ? 1 : 0);
      1:       nxt = clr ? 2 : (run ? 0 : 1);
      default: nxt = 0;
    endcase
    if (nxt == 2 || m_state == 2) begin
      m_cnt = 0;
    end else if (m_state == 1 && tk && !clr) begin
      if (m_mode == 0) m_cnt = (m_cnt == MAX_CNT) ? 0 : m_cnt + 1;
      else             m_cnt = (m_cnt == 0) ? MAX_CNT : m_cnt - 1;
    end
    if (md) m_mode = 1 - m_mode;
    m_state   = nxt;
    e.cnt     = m_cnt;
    e.running = (nxt == 1) ? 1 : 0;
    e.mode    = m_mode;
    e.st      = nxt;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of inputs (called at posedge+1), then compare after the
  // next rising edge.
  task automatic cyc(input bit run, input bit clr, input bit md, input bit tk);
    exp_t e;
    i_run_btn   = run;
    i_clear_btn = clr;
    i_mode_btn  = md;
    i_tick      = tk;
    model_step(run, clr, md, tk);
    @(posedge clk);
    #1;
    i_run_btn   = 1'b0;
    i_clear_btn = 1'b0;
    i_mode_btn  = 1'b0;
    i_tick      = 1'b0;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check_eq("sb_cnt",     int'(o_cnt),     e.cnt);
      check_eq("sb_running", int'(o_running), e.running);
      check_eq("sb_mode",    int'(o_mode),    e.mode);
      check_eq("sb_state",   int'(o_state),   e.st);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_cnt"},     int'(o_cnt),     0);
    check_eq({tag, "_running"}, int'(o_running), 0);
    check_eq({tag, "_mode"},    int'(o_mode),    0);
    check_eq({tag, "_state"},   int'(o_state),   0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rstn        = 1'b1;
    i_tick      = 1'b0;
    i_run_btn   = 1'b0;
    i_clear_btn = 1'b0;
    i_mode_btn  = 1'b0;
    model_reset();

    // Asynchronous reset before any clock edge
    #2 rstn = 1'b0;
    #1 check_all_zero("rst_async");
    @(posedge clk);
    @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1 check_all_zero("rst_release");

    // Run, then three up ticks, one-cycle latency each
    cyc(1, 0, 0, 0);
    check_eq("run_state",   int'(o_state),   1);
    check_eq("run_running", int'(o_running), 1);
    cyc(0, 0, 0, 1); check_eq("tick1", int'(o_cnt), 1);
    cyc(0, 0, 0, 1); check_eq("tick2", int'(o_cnt), 2);
    cyc(0, 0, 0, 1); check_eq("tick3", int'(o_cnt), 3);
    cyc(0, 0, 0, 0); check_eq("idle_hold", int'(o_cnt), 3);

    // Run/tick collision in RUN at 7
    ticks(4);
    check_eq("pre_coll_cnt", int'(o_cnt), 7);
    cyc(1, 0, 0, 1);
    check_eq("runtick_cnt",   int'(o_cnt),   8);
    check_eq("runtick_state", int'(o_state), 0);
    ticks(3);
    check_eq("stop_hold", int'(o_cnt), 8);

    // Run/tick collision in STOP: tick ignored, FSM enters RUN
    cyc(1, 0, 0, 1);
    check_eq("stoptick_cnt",   int'(o_cnt),   8);
    check_eq("stoptick_state", int'(o_state), 1);

    // Clear priority from RUN at 5
    cyc(0, 1, 0, 0);
    check_eq("clr_state", int'(o_state), 2);
    check_eq("clr_cnt",   int'(o_cnt),   0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    ticks(5);
    check_eq("pre_clr_cnt", int'(o_cnt), 5);
    cyc(1, 1, 0, 1);
    check_eq("clrpri_state",   int'(o_state),   2);
    check_eq("clrpri_cnt",     int'(o_cnt),     0);
    check_eq("clrpri_running", int'(o_running), 0);
    cyc(1, 1, 0, 0);  // buttons ignored in CLEAR
    check_eq("after_clr_state",   int'(o_state),   0);
    check_eq("after_clr_running", int'(o_running), 0);

    // Mode/tick collision at 10
    cyc(1, 0, 0, 0);
    ticks(10);
    cyc(0, 0, 1, 1);
    check_eq("modetick_cnt",  int'(o_cnt),  11);
    check_eq("modetick_mode", int'(o_mode), 1);
    cyc(0, 0, 0, 1);
    check_eq("down_tick_cnt", int'(o_cnt), 10);
    cyc(0, 0, 1, 0);
    check_eq("mode_back", int'(o_mode), 0);

    // Up wrap at MAX_CNT, then down wrap at 0
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    ticks(MAX_CNT);
    check_eq("at_max", int'(o_cnt), MAX_CNT);
    cyc(0, 0, 0, 1);
    check_eq("up_wrap", int'(o_cnt), 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    check_eq("down_wrap", int'(o_cnt), MAX_CNT);
    cyc(0, 0, 1, 0);

    // Mode toggles while in CLEAR
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    check_eq("clr_mode_toggle", int'(o_mode), 1);
    cyc(0, 0, 1, 0);

    // Reset mid-run at 1234
    cyc(1, 0, 0, 0);
    ticks(1234);
    check_eq("pre_rst_cnt", int'(o_cnt), 1234);
    #3 rstn = 1'b0;
    #1 check_all_zero("rst_mid");
    model_reset();
    @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;
    ticks(3);
    check_eq("post_rst_cnt",   int'(o_cnt),   0);
    check_eq("post_rst_state", int'(o_state), 0);

    // Random buttons and ticks; buttons sparse, ticks frequent
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 14) == 0), ($urandom_range(0, 1) == 1));
    end
    check_eq("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
